// File: rtl/fpu_request_arbiter.sv
// Two-requester front end for a single shared Fixed_Point_Unit: round-robin
// grant, operand hold until fpu_ready, flush cycle between jobs, hang timeout.
module fpu_request_arbiter #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned FBITS   = 10,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,

    output logic             resp0_valid,
    input  logic             resp0_ready,
    output logic             resp1_valid,
    input  logic             resp1_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_error,

    output logic [WIDTH-1:0] fpu_operand_1,
    output logic [WIDTH-1:0] fpu_operand_2,
    output logic [1:0]       fpu_operation,
    input  logic [WIDTH-1:0] fpu_result,
    input  logic             fpu_ready,

    output logic             busy,
    output logic             grant_id
);

    localparam int unsigned CNT_W = 8;

    // Operation codes shared with the Fixed_Point_Unit
    localparam logic [1:0] OP_ADD  = 2'd0;
    localparam logic [1:0] OP_SUB  = 2'd1;
    localparam logic [1:0] OP_MUL  = 2'd2;
    localparam logic [1:0] OP_SQRT = 2'd3;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("fpu_request_arbiter: TIMEOUT must be in [2, 255]");
    end
    if (FBITS >= WIDTH) begin : g_bad_fbits
        $error("fpu_request_arbiter: FBITS must be below WIDTH");
    end

    logic [1:0]       state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             grant_id_q, grant_id_d;
    logic             resp0_valid_q, resp0_valid_d;
    logic             resp1_valid_q, resp1_valid_d;
    logic [WIDTH-1:0] resp_data_q, resp_data_d;
    logic             resp_error_q, resp_error_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       fpu_op_q, fpu_op_d;
    logic [WIDTH-1:0] fpu_a_q, fpu_a_d;
    logic [WIDTH-1:0] fpu_b_q, fpu_b_d;

    logic             pick_id_c;
    logic             accept0_c;
    logic             accept1_c;
    logic             multi_cycle_c;
    logic             fpu_done_c;
    logic             timeout_c;
    logic             resp_taken_c;

    // Round-robin pick: a lone requester wins, a tie goes against last_grant
    always_comb begin
        pick_id_c = 1'b0;
        if (req0_valid && req1_valid) begin
            pick_id_c = ~last_grant_q;
        end else if (req1_valid) begin
            pick_id_c = 1'b1;
        end
    end

    assign accept0_c = (state_q == S_IDLE) && req0_valid && !pick_id_c;
    assign accept1_c = (state_q == S_IDLE) && req1_valid &&  pick_id_c;

    // MUL/SQRT sequencers may show a stale ready on their first cycle
    assign multi_cycle_c = (fpu_op_q == OP_MUL) || (fpu_op_q == OP_SQRT);
    assign fpu_done_c    = fpu_ready && !((cnt_q == '0) && multi_cycle_c);
    assign timeout_c     = (cnt_q == CNT_W'(TIMEOUT - 1));
    assign resp_taken_c  = grant_id_q ? resp1_ready : resp0_ready;

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        grant_id_d    = grant_id_q;
        resp0_valid_d = resp0_valid_q;
        resp1_valid_d = resp1_valid_q;
        resp_data_d   = resp_data_q;
        resp_error_d  = resp_error_q;
        cnt_d         = cnt_q;
        fpu_op_d      = fpu_op_q;
        fpu_a_d       = fpu_a_q;
        fpu_b_d       = fpu_b_q;

        case (state_q)
            S_IDLE: begin
                if (accept0_c || accept1_c) begin
                    fpu_op_d     = accept1_c ? req1_op : req0_op;
                    fpu_a_d      = accept1_c ? req1_a  : req0_a;
                    fpu_b_d      = accept1_c ? req1_b  : req0_b;
                    grant_id_d   = accept1_c;
                    last_grant_d = accept1_c;
                    cnt_d        = '0;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (fpu_done_c || timeout_c) begin
                    resp_data_d   = fpu_done_c ? fpu_result : '0;
                    resp_error_d  = !fpu_done_c;
                    resp0_valid_d = !grant_id_q;
                    resp1_valid_d =  grant_id_q;
                    state_d       = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                if (resp_taken_c) begin
                    resp0_valid_d = 1'b0;
                    resp1_valid_d = 1'b0;
                    // Zero-operand ADD during GAP flushes the FPU sequencers
                    fpu_op_d      = OP_ADD;
                    fpu_a_d       = '0;
                    fpu_b_d       = '0;
                    state_d       = S_GAP;
                end
            end
            S_GAP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            last_grant_q  <= 1'b1;
            grant_id_q    <= 1'b0;
            resp0_valid_q <= 1'b0;
            resp1_valid_q <= 1'b0;
            resp_data_q   <= '0;
            resp_error_q  <= 1'b0;
            busy_q        <= 1'b0;
            cnt_q         <= '0;
            fpu_op_q      <= OP_ADD;
            fpu_a_q       <= '0;
            fpu_b_q       <= '0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            grant_id_q    <= grant_id_d;
            resp0_valid_q <= resp0_valid_d;
            resp1_valid_q <= resp1_valid_d;
            resp_data_q   <= resp_data_d;
            resp_error_q  <= resp_error_d;
            busy_q        <= busy_d;
            cnt_q         <= cnt_d;
            fpu_op_q      <= fpu_op_d;
            fpu_a_q       <= fpu_a_d;
            fpu_b_q       <= fpu_b_d;
        end
    end

    assign req0_ready    = accept0_c;
    assign req1_ready    = accept1_c;
    assign resp0_valid   = resp0_valid_q;
    assign resp1_valid   = resp1_valid_q;
    assign resp_data     = resp_data_q;
    assign resp_error    = resp_error_q;
    assign fpu_operation = fpu_op_q;
    assign fpu_operand_1 = fpu_a_q;
    assign fpu_operand_2 = fpu_b_q;
    assign busy          = busy_q;
    assign grant_id      = grant_id_q;

endmodule

// File: tb/tb_fpu_request_arbiter.sv
// Bench for fpu_request_arbiter: behavioural multi-cycle FPU stub plus a
// response scoreboard filled at issue time and drained on response handshakes.
module tb_fpu_request_arbiter;

    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 64;

    localparam logic [1:0] OP_ADD  = 2'd0;
    localparam logic [1:0] OP_SUB  = 2'd1;
    localparam logic [1:0] OP_MUL  = 2'd2;
    localparam logic [1:0] OP_SQRT = 2'd3;

    typedef struct packed {
        logic        id;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [1:0]  req0_op = OP_ADD, req1_op = OP_ADD;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic        resp0_valid, resp1_valid;
    logic        resp0_ready = 1'b1, resp1_ready = 1'b1;
    logic [31:0] resp_data;
    logic        resp_error;
    logic [31:0] fpu_operand_1, fpu_operand_2, fpu_result;
    logic [1:0]  fpu_operation;
    logic        fpu_ready;
    logic        busy, grant_id;

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    fpu_request_arbiter #(.WIDTH(WIDTH), .FBITS(10), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
        .resp_data(resp_data), .resp_error(resp_error),
        .fpu_operand_1(fpu_operand_1), .fpu_operand_2(fpu_operand_2),
        .fpu_operation(fpu_operation), .fpu_result(fpu_result),
        .fpu_ready(fpu_ready), .busy(busy), .grant_id(grant_id)
    );

    // Q22.10 FPU stand-in: ADD/SUB combinational, MUL 3 and SQRT 5 cycles
    logic        stuck = 1'b0;
    logic [2:0]  m_cnt_q;
    logic        m_done_q;
    logic [31:0] m_res_q;
    logic        addsub_c;

    function automatic logic [31:0] fx_mul(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        return 32'(p >> 10);
    endfunction

    function automatic logic [31:0] fx_sqrt(input logic [31:0] a);
        logic [63:0] v, r, t;
        v = {22'd0, a, 10'd0};
        r = '0;
        for (int i = 31; i >= 0; i--) begin
            t = r | (64'd1 << i);
            if (t * t <= v) r = t;
        end
        return 32'(r);
    endfunction

    assign addsub_c = (fpu_operation == OP_ADD) || (fpu_operation == OP_SUB);

    always_ff @(posedge clk) begin
        if (addsub_c) begin
            m_cnt_q  <= '0;
            m_done_q <= 1'b0;
            m_res_q  <= '0;
        end else if (!m_done_q) begin
            if (m_cnt_q == ((fpu_operation == OP_MUL) ? 3'd2 : 3'd4)) begin
                m_done_q <= 1'b1;
                m_res_q  <= (fpu_operation == OP_MUL) ? fx_mul(fpu_operand_1, fpu_operand_2)
                                                      : fx_sqrt(fpu_operand_1);
            end
            m_cnt_q <= m_cnt_q + 3'd1;
        end
    end

    assign fpu_ready  = stuck ? 1'b0 : (addsub_c ? 1'b1 : m_done_q);
    assign fpu_result = !addsub_c ? m_res_q :
                        (fpu_operation == OP_ADD) ? fpu_operand_1 + fpu_operand_2
                                                  : fpu_operand_1 - fpu_operand_2;

    // Scoreboard: compare each response at the cycle it is handed over
    always @(negedge clk) begin
        if (!reset) begin
            if (resp0_valid && resp1_valid) begin
                tests++;
                fails++;
                $display("FAIL both_resp_valid: resp0_valid=1 resp1_valid=1, required at most one");
            end
            if ((resp0_valid && resp0_ready) || (resp1_valid && resp1_ready)) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_resp: id=%0d data=%h with no job outstanding",
                             resp1_valid, resp_data);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (resp1_valid !== e.id || resp_data !== e.data || resp_error !== e.err) begin
                        fails++;
                        $display("FAIL sb_resp: got id=%0d data=%h err=%0d, required id=%0d data=%h err=%0d",
                                 resp1_valid, resp_data, resp_error, e.id, e.data, e.err);
                    end
                end
            end
        end
    end

    task automatic push(input logic id, input logic [31:0] data, input logic err);
        exp_t e;
        e.id = id; e.data = data; e.err = err;
        sb.push_back(e);
    endtask

    // Present a job and return once its handshake edge has passed
    task automatic issue(input logic id, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, output int waited);
        waited = 0;
        @(posedge clk); #1;
        if (id) begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end
        forever begin
            @(negedge clk);
            if (id ? req1_ready : req0_ready) break;
            waited++;
            if (waited > 300) begin
                tests++;
                fails++;
                $display("FAIL issue_handshake: req%0d_ready=0 after %0d cycles, required 1", id, waited);
                break;
            end
        end
        @(posedge clk); #1;
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    task automatic wait_resp(input logic id, output int lat);
        lat = 0;
        forever begin
            @(negedge clk);
            lat++;
            if (id ? resp1_valid : resp0_valid) break;
            if (lat > 300) begin
                tests++;
                fails++;
                $display("FAIL resp_wait: resp%0d_valid=0 after %0d cycles, required 1", id, lat);
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %0d, required 0", busy); end
        tests++; if ({resp0_valid, resp1_valid} !== 2'b00) begin fails++; $display("FAIL rst_valids: got %b, required 00", {resp0_valid, resp1_valid}); end
        tests++; if (resp_data !== 32'h0 || resp_error !== 1'b0) begin fails++; $display("FAIL rst_resp: data=%h err=%0d, required 0/0", resp_data, resp_error); end
        tests++; if (fpu_operation !== OP_ADD || fpu_operand_1 !== 32'h0 || fpu_operand_2 !== 32'h0) begin
            fails++; $display("FAIL rst_fpu: op=%0d a=%h b=%h, required 0/0/0", fpu_operation, fpu_operand_1, fpu_operand_2); end
        tests++; if (grant_id !== 1'b0) begin fails++; $display("FAIL rst_grant: got %0d, required 0", grant_id); end
        #1 req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        tests++; if ({req0_ready, req1_ready} !== 2'b10) begin fails++; $display("FAIL rst_first_pick: ready=%b, required 10", {req0_ready, req1_ready}); end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL withdraw_busy: got %0d, required 0", busy); end
    endtask

    task automatic test_add();
        int w, lat;
        push(1'b0, 32'h0000_0E00, 1'b0);
        issue(1'b0, OP_ADD, 32'h0000_0600, 32'h0000_0800, w);
        tests++; if (w != 0) begin fails++; $display("FAIL add_accept: ready after %0d cycles, required 0", w); end
        wait_resp(1'b0, lat);
        tests++; if (lat != 2) begin fails++; $display("FAIL add_latency: got %0d, required 2", lat); end
        tests++; if (resp1_valid !== 1'b0) begin fails++; $display("FAIL add_other_valid: got %0d, required 0", resp1_valid); end
        @(negedge clk);
        tests++; if (fpu_operation !== OP_ADD || fpu_operand_1 !== 32'h0 || fpu_operand_2 !== 32'h0 || busy !== 1'b1) begin
            fails++; $display("FAIL add_gap: op=%0d a=%h b=%h busy=%0d, required 0/0/0/1", fpu_operation, fpu_operand_1, fpu_operand_2, busy); end
        @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL add_idle: busy=%0d, required 0", busy); end
    endtask

    task automatic test_mul();
        int w, lat, bad, r0;
        push(1'b1, 32'h0000_0C00, 1'b0);
        issue(1'b1, OP_MUL, 32'h0000_0600, 32'h0000_0800, w);
        lat = 0; bad = 0; r0 = 0;
        forever begin
            @(negedge clk);
            lat++;
            if (resp0_valid) r0++;
            if (resp1_valid) break;
            if (fpu_operation !== OP_MUL || fpu_operand_1 !== 32'h600 || fpu_operand_2 !== 32'h800) bad++;
            if (lat > TIMEOUT + 4) break;
        end
        tests++; if (resp1_valid !== 1'b1 || lat > TIMEOUT) begin fails++; $display("FAIL mul_latency: got %0d valid=%0d, required <= %0d", lat, resp1_valid, TIMEOUT); end
        tests++; if (bad != 0) begin fails++; $display("FAIL mul_hold: %0d unstable ISSUE cycles, required 0", bad); end
        tests++; if (r0 != 0) begin fails++; $display("FAIL mul_resp0: resp0_valid high %0d cycles, required 0", r0); end
        tests++; if (grant_id !== 1'b1) begin fails++; $display("FAIL mul_grant: got %0d, required 1", grant_id); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int w, lat;
        push(1'b0, 32'h0000_0800, 1'b0);
        issue(1'b0, OP_SQRT, 32'h0000_1000, 32'h0, w);
        wait_resp(1'b0, lat);
        @(negedge clk);
        tests++; if (fpu_operation === OP_SQRT || busy !== 1'b1) begin fails++; $display("FAIL b2b_gap: op=%0d busy=%0d, required non-SQRT/1", fpu_operation, busy); end
        push(1'b0, 32'h0000_0C00, 1'b0);
        issue(1'b0, OP_SQRT, 32'h0000_2400, 32'h0, w);
        wait_resp(1'b0, lat);
        tests++; if (resp_data !== 32'h0000_0C00) begin fails++; $display("FAIL b2b_second_root: got %h, required 00000c00", resp_data); end
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        int n;
        logic g;
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        push(1'b0, 32'h0000_4000, 1'b0);
        push(1'b1, 32'h0000_2800, 1'b0);
        push(1'b0, 32'h0000_4000, 1'b0);
        push(1'b1, 32'h0000_2800, 1'b0);
        req0_op = OP_SUB; req0_a = 32'h5000; req0_b = 32'h1000;
        req1_op = OP_SUB; req1_a = 32'h3000; req1_b = 32'h0800;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int j = 0; j < 4; j++) begin
            n = 0;
            forever begin
                @(negedge clk);
                n++;
                if (req0_ready || req1_ready || n > 50) break;
            end
            g = req1_ready;
            tests++; if ({req0_ready, req1_ready} !== ((j % 2 == 0) ? 2'b10 : 2'b01)) begin
                fails++; $display("FAIL rr_grant%0d: ready=%b, required %b", j, {req0_ready, req1_ready}, (j % 2 == 0) ? 2'b10 : 2'b01); end
            if (j > 0) begin
                tests++; if (n != 4) begin fails++; $display("FAIL rr_spacing%0d: got %0d cycles, required 4 (grant %0d)", j, n, g); end
            end
            @(posedge clk); #1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 50) begin @(negedge clk); n++; end
        tests++; if (sb.size() != 0) begin fails++; $display("FAIL rr_drain: %0d responses missing, required 0", sb.size()); end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int w, lat;
        stuck = 1'b1;
        push(1'b1, 32'h0, 1'b1);
        issue(1'b1, OP_ADD, 32'h0000_0100, 32'h0000_0200, w);
        wait_resp(1'b1, lat);
        tests++; if (lat != TIMEOUT + 1) begin fails++; $display("FAIL to_latency: got %0d, required %0d", lat, TIMEOUT + 1); end
        tests++; if (resp_error !== 1'b1 || resp_data !== 32'h0) begin fails++; $display("FAIL to_resp: err=%0d data=%h, required 1/0", resp_error, resp_data); end
        stuck = 1'b0;
        @(negedge clk);
        push(1'b0, 32'h0000_0E00, 1'b0);
        issue(1'b0, OP_ADD, 32'h0000_0600, 32'h0000_0800, w);
        wait_resp(1'b0, lat);
        tests++; if (lat != 2) begin fails++; $display("FAIL to_recover: latency %0d, required 2", lat); end
        @(negedge clk);
    endtask

    task automatic test_stall_reset();
        int w, lat, bad;
        @(posedge clk); #1 resp0_ready = 1'b0;
        push(1'b0, 32'h0000_0E00, 1'b0);
        issue(1'b0, OP_ADD, 32'h0000_0600, 32'h0000_0800, w);
        push(1'b1, 32'h0000_0200, 1'b0);
        req1_op = OP_ADD; req1_a = 32'h100; req1_b = 32'h100; req1_valid = 1'b1;
        wait_resp(1'b0, lat);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (req1_ready !== 1'b0 || resp_data !== 32'h0000_0E00 || resp0_valid !== 1'b1) bad++;
        end
        tests++; if (bad != 0) begin fails++; $display("FAIL stall_hold: %0d bad cycles, required 0", bad); end
        @(posedge clk); #1 resp0_ready = 1'b1;
        issue(1'b1, OP_ADD, 32'h100, 32'h100, w);
        wait_resp(1'b1, lat);
        tests++; if (lat != 2) begin fails++; $display("FAIL stall_next: latency %0d, required 2", lat); end
        @(negedge clk);

        stuck = 1'b1;
        issue(1'b0, OP_MUL, 32'h0000_0600, 32'h0000_0800, w);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        tests++; if (busy !== 1'b0 || {resp0_valid, resp1_valid} !== 2'b00 || fpu_operation !== OP_ADD) begin
            fails++; $display("FAIL mid_reset: busy=%0d valids=%b op=%0d, required 0/00/0", busy, {resp0_valid, resp1_valid}, fpu_operation); end
        stuck = 1'b0;
        bad = 0;
        repeat (5) begin @(negedge clk); if (resp0_valid || resp1_valid || busy) bad++; end
        tests++; if (bad != 0) begin fails++; $display("FAIL mid_reset_discard: %0d active cycles, required 0", bad); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_mul();
        test_back_to_back();
        test_round_robin();
        test_timeout();
        test_stall_reset();
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL sb_leftover: %0d expected responses never seen, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
